// File: rtl/rs_multi_entry.sv
// Reservation station for one functional unit: holds dispatched ops until both
// source operands arrive from the CDB, then issues the oldest ready op.
module rs_multi_entry #(
  parameter int DEPTH         = 4,
  parameter int ROB_IDX_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_CDB       = 4,
  parameter int PAYLOAD_WIDTH = 96
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              disp_valid,
  output logic                              disp_ready,
  input  logic [ROB_IDX_WIDTH-1:0]          disp_rd_rob,
  input  logic                              disp_rs1_rdy,
  input  logic [ROB_IDX_WIDTH-1:0]          disp_rs1_tag,
  input  logic [DATA_WIDTH-1:0]             disp_rs1_data,
  input  logic                              disp_rs2_rdy,
  input  logic [ROB_IDX_WIDTH-1:0]          disp_rs2_tag,
  input  logic [DATA_WIDTH-1:0]             disp_rs2_data,
  input  logic [PAYLOAD_WIDTH-1:0]          disp_payload,
  input  logic [NUM_CDB-1:0]                cdb_valid,
  input  logic [NUM_CDB*ROB_IDX_WIDTH-1:0]  cdb_rob_idx,
  input  logic [NUM_CDB*DATA_WIDTH-1:0]     cdb_data,
  output logic                              issue_valid,
  input  logic                              issue_ready,
  output logic [ROB_IDX_WIDTH-1:0]          issue_rd_rob,
  output logic [DATA_WIDTH-1:0]             issue_rs1_data,
  output logic [DATA_WIDTH-1:0]             issue_rs2_data,
  output logic [PAYLOAD_WIDTH-1:0]          issue_payload,
  output logic [$clog2(DEPTH+1)-1:0]        occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]         ent_vld;
  logic [DEPTH-1:0]         ent_rs1_rdy;
  logic [DEPTH-1:0]         ent_rs2_rdy;
  logic [ROB_IDX_WIDTH-1:0] ent_rd_rob   [DEPTH];
  logic [ROB_IDX_WIDTH-1:0] ent_rs1_tag  [DEPTH];
  logic [ROB_IDX_WIDTH-1:0] ent_rs2_tag  [DEPTH];
  logic [DATA_WIDTH-1:0]    ent_rs1_data [DEPTH];
  logic [DATA_WIDTH-1:0]    ent_rs2_data [DEPTH];
  logic [PAYLOAD_WIDTH-1:0] ent_payload  [DEPTH];
  logic [DEPTH-1:0]         age          [DEPTH];
  logic [CNT_W-1:0]         cnt;

  logic [DEPTH-1:0]         rdy_vec;
  logic [DEPTH-1:0]         older_rdy;
  logic [IDX_W-1:0]         alloc_idx;
  logic [IDX_W-1:0]         sel_idx;
  logic                     disp_fire;
  logic                     issue_fire;

  function automatic logic cdb_hit(
    input logic [ROB_IDX_WIDTH-1:0]         tag,
    input logic [NUM_CDB-1:0]               v,
    input logic [NUM_CDB*ROB_IDX_WIDTH-1:0] t
  );
    cdb_hit = 1'b0;
    for (int k = 0; k < NUM_CDB; k++)
      if (v[k] && (t[k*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] == tag)) cdb_hit = 1'b1;
  endfunction

  // Scans high-to-low so the lowest matching channel is the one that sticks.
  function automatic logic [DATA_WIDTH-1:0] cdb_pick(
    input logic [ROB_IDX_WIDTH-1:0]         tag,
    input logic [NUM_CDB-1:0]               v,
    input logic [NUM_CDB*ROB_IDX_WIDTH-1:0] t,
    input logic [NUM_CDB*DATA_WIDTH-1:0]    d
  );
    cdb_pick = '0;
    for (int k = NUM_CDB-1; k >= 0; k--)
      if (v[k] && (t[k*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] == tag))
        cdb_pick = d[k*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  assign rdy_vec     = ent_vld & ent_rs1_rdy & ent_rs2_rdy;
  assign issue_valid = |rdy_vec;
  assign disp_ready  = (cnt < CNT_W'(DEPTH));
  assign occupancy   = cnt;
  assign disp_fire   = disp_valid && disp_ready;
  assign issue_fire  = issue_valid && issue_ready;

  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!ent_vld[i]) alloc_idx = IDX_W'(i);
  end

  // An entry is selected when no other ready entry is marked older than it.
  always_comb begin
    older_rdy = '0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++)
        if (rdy_vec[j] && age[j][i]) older_rdy[i] = 1'b1;
    for (int i = 0; i < DEPTH; i++)
      if (rdy_vec[i] && !older_rdy[i]) sel_idx = IDX_W'(i);
  end

  assign issue_rd_rob   = ent_rd_rob[sel_idx];
  assign issue_rs1_data = ent_rs1_data[sel_idx];
  assign issue_rs2_data = ent_rs2_data[sel_idx];
  assign issue_payload  = ent_payload[sel_idx];

  // Control state: occupancy, valid bits and age matrix.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ent_vld <= '0;
      cnt     <= '0;
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else begin
      if (issue_fire) ent_vld[sel_idx] <= 1'b0;
      if (disp_fire) begin
        ent_vld[alloc_idx] <= 1'b1;
        for (int j = 0; j < DEPTH; j++) begin
          age[alloc_idx][j] <= 1'b0;
          if (ent_vld[j]) age[j][alloc_idx] <= 1'b1;
        end
      end
      cnt <= cnt + CNT_W'(disp_fire) - CNT_W'(issue_fire);
    end
  end

  // Entry contents: operand capture on dispatch (with CDB bypass) and wakeup.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && !ent_rs1_rdy[i] && cdb_hit(ent_rs1_tag[i], cdb_valid, cdb_rob_idx)) begin
        ent_rs1_rdy[i]  <= 1'b1;
        ent_rs1_data[i] <= cdb_pick(ent_rs1_tag[i], cdb_valid, cdb_rob_idx, cdb_data);
      end
      if (ent_vld[i] && !ent_rs2_rdy[i] && cdb_hit(ent_rs2_tag[i], cdb_valid, cdb_rob_idx)) begin
        ent_rs2_rdy[i]  <= 1'b1;
        ent_rs2_data[i] <= cdb_pick(ent_rs2_tag[i], cdb_valid, cdb_rob_idx, cdb_data);
      end
    end
    if (disp_fire) begin
      ent_rd_rob[alloc_idx]   <= disp_rd_rob;
      ent_payload[alloc_idx]  <= disp_payload;
      ent_rs1_tag[alloc_idx]  <= disp_rs1_tag;
      ent_rs2_tag[alloc_idx]  <= disp_rs2_tag;
      ent_rs1_rdy[alloc_idx]  <= disp_rs1_rdy || cdb_hit(disp_rs1_tag, cdb_valid, cdb_rob_idx);
      ent_rs2_rdy[alloc_idx]  <= disp_rs2_rdy || cdb_hit(disp_rs2_tag, cdb_valid, cdb_rob_idx);
      ent_rs1_data[alloc_idx] <= disp_rs1_rdy ? disp_rs1_data
                               : cdb_pick(disp_rs1_tag, cdb_valid, cdb_rob_idx, cdb_data);
      ent_rs2_data[alloc_idx] <= disp_rs2_rdy ? disp_rs2_data
                               : cdb_pick(disp_rs2_tag, cdb_valid, cdb_rob_idx, cdb_data);
    end
  end

endmodule
